// File: rtl/zclk_return_rx_if.sv
// ============================================================================
// zclk_return_rx_if : status/strobe bundle between zclk_return_rx and its users
// Rev 1.0
// ============================================================================
`default_nettype none

interface zclk_return_rx_if;
  logic       zclk;
  logic       zpos_exp;
  logic       err_clr;
  logic       rz_pos;
  logic       rz_neg;
  logic [5:0] period;
  logic       period_vld;
  logic [1:0] rate;
  logic       stall;
  logic       err_miss;
  logic       err_spur;
  logic [7:0] err_cnt;

  modport slave (
    input  zclk, zpos_exp, err_clr,
    output rz_pos, rz_neg, period, period_vld, rate, stall,
           err_miss, err_spur, err_cnt
  );

  modport master (
    output zclk, zpos_exp, err_clr,
    input  rz_pos, rz_neg, period, period_vld, rate, stall,
           err_miss, err_spur, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/zclk_return_rx.sv
// ============================================================================
// zclk_return_rx : recovers returned Z80 clock edges, period, rate and stall;
// zpos cross-checker built only with ZCLK_RX_CHECK_EN defined.  Rev 1.0
// ============================================================================
`default_nettype none

module zclk_return_rx #(
  parameter int STALL_LIM = 32,
  parameter int WIN       = 4
) (
  input wire              fclk,
  input wire              rst_n,
  zclk_return_rx_if.slave bus
);

  localparam logic [5:0] c_stall_lim = 6'(STALL_LIM);
  localparam logic [5:0] c_pc_max    = 6'd63;

  logic       s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [1:0] arm_q, arm_d;
  logic       armed;
  logic       rz_pos_q, rz_pos_d, rz_neg_q, rz_neg_d;
  logic [5:0] pc_q, pc_d;
  logic [5:0] period_q, period_d;
  logic       period_vld_q, period_vld_d;
  logic [1:0] rate_q, rate_d;
  logic       stall_q, stall_d;
  logic       seen_q, seen_d;

  function automatic logic [1:0] rate_of(input logic [5:0] p);
    if (p <= 6'd2)       return 2'b10;
    else if (p <= 6'd5)  return 2'b01;
    else if (p <= 6'd10) return 2'b00;
    else                 return 2'b11;
  endfunction

  always_comb begin
    s1_d  = bus.zclk;
    s2_d  = s1_q;
    s3_d  = s2_q;
    armed = (arm_q == 2'd3);
    arm_d = armed ? arm_q : arm_q + 2'd1;

    // Arming keeps a zclk already high at reset release from looking like a rise
    rz_pos_d = s2_q & ~s3_q & armed;
    rz_neg_d = ~s2_q & s3_q & armed;

    pc_d = rz_pos_q ? 6'd1 : ((pc_q == c_pc_max) ? pc_q : pc_q + 6'd1);

    period_d     = period_q;
    period_vld_d = period_vld_q;
    rate_d       = rate_q;
    stall_d      = stall_q;
    seen_d       = seen_q;

    if (rz_pos_q) begin
      period_d     = pc_q;
      period_vld_d = seen_q;
      rate_d       = seen_q ? rate_of(pc_q) : 2'b11;
      seen_d       = 1'b1;
      stall_d      = 1'b0;
    end else if (pc_q == c_stall_lim) begin
      stall_d      = 1'b1;
      period_vld_d = 1'b0;
      rate_d       = 2'b11;
      seen_d       = 1'b0;
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      arm_q        <= 2'd0;
      rz_pos_q     <= 1'b0;
      rz_neg_q     <= 1'b0;
      pc_q         <= 6'd0;
      period_q     <= 6'd0;
      period_vld_q <= 1'b0;
      rate_q       <= 2'b11;
      stall_q      <= 1'b0;
      seen_q       <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      arm_q        <= arm_d;
      rz_pos_q     <= rz_pos_d;
      rz_neg_q     <= rz_neg_d;
      pc_q         <= pc_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      rate_q       <= rate_d;
      stall_q      <= stall_d;
      seen_q       <= seen_d;
    end
  end

  assign bus.rz_pos     = rz_pos_q;
  assign bus.rz_neg     = rz_neg_q;
  assign bus.period     = period_q;
  assign bus.period_vld = period_vld_q;
  assign bus.rate       = rate_q;
  assign bus.stall      = stall_q;

`ifdef ZCLK_RX_CHECK_EN
  localparam logic [3:0] c_win = 4'(WIN);

  logic       pend_q, pend_d;
  logic [3:0] wc_q, wc_d;
  logic       err_miss_q, err_miss_d, err_spur_q, err_spur_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    pend_d     = pend_q;
    wc_d       = wc_q;
    err_miss_d = 1'b0;
    err_spur_d = 1'b0;

    if (bus.zpos_exp) begin
      if (pend_q && !rz_pos_q) err_miss_d = 1'b1;
      if (!pend_q && rz_pos_q) begin
        pend_d = 1'b0;
      end else begin
        pend_d = 1'b1;
        wc_d   = c_win;
      end
    end else if (pend_q) begin
      // Window expires when wc would decrement to zero without a rise
      if (rz_pos_q) begin
        pend_d = 1'b0;
      end else if (wc_q <= 4'd1) begin
        err_miss_d = 1'b1;
        pend_d     = 1'b0;
        wc_d       = 4'd0;
      end else begin
        wc_d = wc_q - 4'd1;
      end
    end else if (rz_pos_q) begin
      err_spur_d = 1'b1;
    end

    err_cnt_d = err_cnt_q;
    if (bus.err_clr)
      err_cnt_d = 8'd0;
    else if ((err_miss_q || err_spur_q) && (err_cnt_q != 8'hff))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      wc_q       <= 4'd0;
      err_miss_q <= 1'b0;
      err_spur_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      pend_q     <= pend_d;
      wc_q       <= wc_d;
      err_miss_q <= err_miss_d;
      err_spur_q <= err_spur_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.err_miss = err_miss_q;
  assign bus.err_spur = err_spur_q;
  assign bus.err_cnt  = err_cnt_q;
`else
  logic unused_inputs;
  assign unused_inputs = bus.zpos_exp ^ bus.err_clr;

  assign bus.err_miss = 1'b0;
  assign bus.err_spur = 1'b0;
  assign bus.err_cnt  = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_zclk_return_rx.sv
// ============================================================================
// tb_zclk_return_rx : scoreboard bench for zclk_return_rx edge/period/stall/checker
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_zclk_return_rx;
  localparam int STALL_LIM = 32;
  localparam int WIN       = 4;
`ifdef ZCLK_RX_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  typedef struct {
    int         cyc;
    int         period;
    bit         chk;
    bit         vld;
    logic [1:0] rate;
  } per_t;

  logic fclk  = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   failures = 0;
  int   pos_q[$];
  int   neg_q[$];
  per_t per_q[$];
  int   prev_rise = -1;
  int   pos_seen = 0;
  int   miss_cnt = 0;
  int   spur_cnt = 0;

  zclk_return_rx_if bus();

  zclk_return_rx #(.STALL_LIM(STALL_LIM), .WIN(WIN)) dut (
    .fclk  (fclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 fclk = ~fclk;
  always @(posedge fclk) cyc <= cyc + 1;

  function automatic logic [1:0] exp_rate(input int p);
    if (p >= 1 && p <= 2)  return 2'b10;
    if (p >= 3 && p <= 5)  return 2'b01;
    if (p >= 6 && p <= 10) return 2'b00;
    return 2'b11;
  endfunction

  // Rise driven now is sampled at the next posedge; strobe follows two edges later.
  task automatic drive_rise();
    per_t e;
    int   r;
    bus.zclk = 1'b1;
    r = cyc + 3;
    pos_q.push_back(r);
    e.cyc    = r + 1;
    e.chk    = (prev_rise >= 0);
    e.period = (r - prev_rise > 63) ? 63 : r - prev_rise;
    e.vld    = (prev_rise >= 0) && (r - prev_rise <= STALL_LIM);
    e.rate   = e.vld ? exp_rate(e.period) : 2'b11;
    per_q.push_back(e);
    prev_rise = r;
  endtask

  task automatic drive_fall();
    bus.zclk = 1'b0;
    neg_q.push_back(cyc + 3);
  endtask

  task automatic zperiod(input int hi, input int lo, input bit exp, input bit rise);
    if (exp)  bus.zpos_exp = 1'b1;
    if (rise) drive_rise();
    @(negedge fclk);
    bus.zpos_exp = 1'b0;
    repeat (hi - 1) @(negedge fclk);
    if (rise) drive_fall();
    repeat (lo) @(negedge fclk);
  endtask

  task automatic drain();
    repeat (8) @(negedge fclk);
    checks++;
    if (pos_q.size() != 0 || neg_q.size() != 0 || per_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending pos=%0d neg=%0d per=%0d want=0", pos_q.size(), neg_q.size(), per_q.size());
    end
  endtask

  task automatic clear_model();
    pos_q.delete();
    neg_q.delete();
    per_q.delete();
    prev_rise = -1;
    pos_seen  = 0;
  endtask

  initial begin : monitor
    int   e;
    per_t p;
    forever begin
      @(negedge fclk);
      if (rst_n) begin
        if (bus.rz_pos) begin
          pos_seen++;
          checks++;
          if (pos_q.size() == 0) begin
            failures++;
            $display("FAIL rz_pos_unexpected cyc=%0d got=1 want=0", cyc);
          end else begin
            e = pos_q.pop_front();
            if (cyc != e) begin
              failures++;
              $display("FAIL rz_pos_time got=%0d want=%0d", cyc, e);
            end
          end
          if (bus.rz_neg) begin
            failures++;
            $display("FAIL rz_both got=11 want=10 cyc=%0d", cyc);
          end
        end else if (pos_q.size() != 0 && cyc > pos_q[0]) begin
          checks++;
          failures++;
          e = pos_q.pop_front();
          $display("FAIL rz_pos_missing got=none want_cyc=%0d", e);
        end

        if (bus.rz_neg) begin
          checks++;
          if (neg_q.size() == 0) begin
            failures++;
            $display("FAIL rz_neg_unexpected cyc=%0d got=1 want=0", cyc);
          end else begin
            e = neg_q.pop_front();
            if (cyc != e) begin
              failures++;
              $display("FAIL rz_neg_time got=%0d want=%0d", cyc, e);
            end
          end
        end else if (neg_q.size() != 0 && cyc > neg_q[0]) begin
          checks++;
          failures++;
          e = neg_q.pop_front();
          $display("FAIL rz_neg_missing got=none want_cyc=%0d", e);
        end

        if (per_q.size() != 0 && cyc >= per_q[0].cyc) begin
          p = per_q.pop_front();
          checks++;
          if (cyc != p.cyc || bus.period_vld !== p.vld || bus.rate !== p.rate ||
              bus.stall !== 1'b0 || (p.chk && bus.period !== 6'(p.period))) begin
            failures++;
            $display("FAIL per_update cyc=%0d/%0d period=%0d/%0d vld=%0b/%0b rate=%b/%b stall=%0b/0",
                     cyc, p.cyc, bus.period, p.period, bus.period_vld, p.vld, bus.rate, p.rate, bus.stall);
          end
        end

        miss_cnt += int'(bus.err_miss);
        spur_cnt += int'(bus.err_spur);
      end
    end
  end

  task automatic test_reset();
    bus.zclk = 1'b0; bus.zpos_exp = 1'b0; bus.err_clr = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge fclk);
    checks++;
    if ({bus.rz_pos, bus.rz_neg, bus.period_vld, bus.stall, bus.err_miss, bus.err_spur} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000000", {bus.rz_pos, bus.rz_neg, bus.period_vld, bus.stall, bus.err_miss, bus.err_spur});
    end
    checks++;
    if (bus.period !== 6'd0) begin failures++; $display("FAIL reset_period got=%0d want=0", bus.period); end
    checks++;
    if (bus.rate !== 2'b11) begin failures++; $display("FAIL reset_rate got=%b want=11", bus.rate); end
    checks++;
    if (bus.err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d want=0", bus.err_cnt); end
    clear_model();
    #2 rst_n = 1'b1;
    repeat (5) @(negedge fclk);
  endtask

  task automatic test_rate_35();
    repeat (4) zperiod(4, 4, 1'b0, 1'b1);
    checks++;
    if (bus.period !== 6'd8 || bus.period_vld !== 1'b1 || bus.rate !== 2'b00) begin
      failures++;
      $display("FAIL rate_35 period=%0d/8 vld=%0b/1 rate=%b/00", bus.period, bus.period_vld, bus.rate);
    end
    drain();
  endtask

  task automatic test_rate_switch();
    repeat (4) zperiod(2, 2, 1'b0, 1'b1);
    checks++;
    if (bus.rate !== 2'b01) begin failures++; $display("FAIL rate_7 got=%b want=01", bus.rate); end
    repeat (4) zperiod(1, 1, 1'b0, 1'b1);
    checks++;
    if (bus.period !== 6'd2 || bus.rate !== 2'b10) begin
      failures++;
      $display("FAIL rate_14 period=%0d/2 rate=%b/10", bus.period, bus.rate);
    end
    drain();
  endtask

  task automatic test_stall();
    int r;
    repeat (2) zperiod(4, 4, 1'b0, 1'b1);
    r = prev_rise;
    while (cyc < r + STALL_LIM) @(negedge fclk);
    checks++;
    if (bus.stall !== 1'b0) begin failures++; $display("FAIL stall_early got=1 want=0"); end
    @(negedge fclk);
    checks++;
    if (bus.stall !== 1'b1 || bus.period_vld !== 1'b0 || bus.rate !== 2'b11) begin
      failures++;
      $display("FAIL stall_set stall=%0b/1 vld=%0b/0 rate=%b/11", bus.stall, bus.period_vld, bus.rate);
    end
    while (cyc < r + 40) @(negedge fclk);
    repeat (2) zperiod(4, 4, 1'b0, 1'b1);
    checks++;
    if (bus.stall !== 1'b0 || bus.period_vld !== 1'b1) begin
      failures++;
      $display("FAIL stall_recover stall=%0b/0 vld=%0b/1", bus.stall, bus.period_vld);
    end
    drain();
  endtask

  task automatic test_reset_zclk_high();
    checks++;
    if (bus.period_vld !== 1'b1) begin failures++; $display("FAIL pre_reset_vld got=0 want=1"); end
    @(negedge fclk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.period !== 6'd0 || bus.period_vld !== 1'b0 || bus.rate !== 2'b11) begin
      failures++;
      $display("FAIL async_reset period=%0d/0 vld=%0b/0 rate=%b/11", bus.period, bus.period_vld, bus.rate);
    end
    bus.zclk = 1'b1;
    repeat (2) @(negedge fclk);
    clear_model();
    #2 rst_n = 1'b1;
    repeat (8) @(negedge fclk);
    checks++;
    if (pos_seen != 0) begin failures++; $display("FAIL high_release_pos got=%0d want=0", pos_seen); end
    drive_fall();
    repeat (6) @(negedge fclk);
    checks++;
    if (neg_q.size() != 0) begin failures++; $display("FAIL high_release_neg pending=%0d want=0", neg_q.size()); end
  endtask

  task automatic test_checker();
    @(negedge fclk); bus.err_clr = 1'b1;
    @(negedge fclk); bus.err_clr = 1'b0;
    miss_cnt = 0; spur_cnt = 0;
    repeat (4) zperiod(4, 4, 1'b1, 1'b1);
    repeat (4) @(negedge fclk);
    checks++;
    if (miss_cnt != 0 || spur_cnt != 0 || bus.err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL chk_match miss=%0d/0 spur=%0d/0 cnt=%0d/0", miss_cnt, spur_cnt, bus.err_cnt);
    end
    zperiod(4, 4, 1'b1, 1'b0);
    repeat (2) zperiod(4, 4, 1'b1, 1'b1);
    repeat (4) @(negedge fclk);
    checks++;
    if (miss_cnt != CHK || spur_cnt != 0 || bus.err_cnt !== 8'(CHK)) begin
      failures++;
      $display("FAIL chk_miss miss=%0d/%0d spur=%0d/0 cnt=%0d/%0d", miss_cnt, CHK, spur_cnt, bus.err_cnt, CHK);
    end
    zperiod(4, 4, 1'b0, 1'b1);
    zperiod(4, 4, 1'b1, 1'b1);
    repeat (4) @(negedge fclk);
    checks++;
    if (spur_cnt != CHK || bus.err_cnt !== 8'(2 * CHK)) begin
      failures++;
      $display("FAIL chk_spur spur=%0d/%0d cnt=%0d/%0d", spur_cnt, CHK, bus.err_cnt, 2 * CHK);
    end
    bus.err_clr = 1'b1;
    @(negedge fclk); bus.err_clr = 1'b0;
    checks++;
    if (bus.err_cnt !== 8'd0) begin failures++; $display("FAIL chk_clear got=%0d want=0", bus.err_cnt); end
    drain();
  endtask

  task automatic test_saturation();
    spur_cnt = 0;
    repeat (300) zperiod(1, 1, 1'b0, 1'b1);
    repeat (6) @(negedge fclk);
    checks++;
    if (spur_cnt != 300 * CHK) begin failures++; $display("FAIL sat_spurs got=%0d want=%0d", spur_cnt, 300 * CHK); end
    checks++;
    if (bus.err_cnt !== 8'(255 * CHK)) begin failures++; $display("FAIL sat_cnt got=%0d want=%0d", bus.err_cnt, 255 * CHK); end
    drain();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout cyc=%0d want=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rate_35();
    test_rate_switch();
    test_stall();
    test_reset_zclk_high();
    test_checker();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
